// File: rtl/dec_scan_pol.sv
// Registered index decoder with direct-select and auto-scan modes.
// Output polarity is selectable, and the outputs can be blanked without disturbing scan timing.
module dec_scan_pol #(
    parameter int SEL_W = 2,
    parameter int DWELL = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  pol,
    input  logic                  blank,
    input  logic                  ld,
    input  logic [SEL_W-1:0]      sel,
    output logic [2**SEL_W-1:0]   d,
    output logic [SEL_W-1:0]      cur_sel,
    output logic                  wrap
);
    localparam int OUT_W = 2**SEL_W;
    localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SEL_W-1:0] IDX_LAST   = SEL_W'(OUT_W - 1);
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

    state_t             state_reg, state_next;
    logic [SEL_W-1:0]   idx_reg, idx_next;
    logic [DW_W-1:0]    dwell_reg, dwell_next;
    logic               wrap_reg, wrap_next;
    logic [OUT_W-1:0]   d_reg, d_next;
    logic [OUT_W-1:0]   dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            dwell_reg <= '0;
            wrap_reg  <= 1'b0;
            d_reg     <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            dwell_reg <= dwell_next;
            wrap_reg  <= wrap_next;
            d_reg     <= d_next;
        end
    end

    always_comb begin
        state_next = !en ? IDLE : (mode ? SCAN : DIRECT);
        idx_next   = idx_reg;
        dwell_next = dwell_reg;
        wrap_next  = 1'b0;
        case (state_next)
            IDLE: begin
                dwell_next = '0;
            end
            DIRECT: begin
                dwell_next = '0;
                if (ld) begin
                    idx_next = sel;
                end
            end
            SCAN: begin
                // Entering scan always restarts from index 0 with a fresh dwell.
                if (state_reg != SCAN) begin
                    idx_next   = '0;
                    dwell_next = '0;
                end else if (dwell_reg == DWELL_LAST) begin
                    dwell_next = '0;
                    idx_next   = idx_reg + SEL_W'(1);
                    wrap_next  = (idx_reg == IDX_LAST);
                end else begin
                    dwell_next = dwell_reg + DW_W'(1);
                end
            end
            default: begin
                dwell_next = '0;
            end
        endcase
    end

    // Active bit takes the value of pol, all other bits take ~pol.
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_dec
        assign dec[gi] = (idx_reg == SEL_W'(gi)) ? pol : ~pol;
    end

    always_comb begin
        d_next = {OUT_W{~pol}};
        if (state_reg != IDLE && !blank) begin
            d_next = dec;
        end
    end

    assign d       = d_reg;
    assign cur_sel = idx_reg;
    assign wrap    = wrap_reg;
endmodule

// File: tb/tb_dec_scan_pol.sv
// Directed checks of dec_scan_pol with SEL_W=2, DWELL=3.
module tb_dec_scan_pol;
    logic       clk = 1'b0;
    logic       rst_n, en, mode, pol, blank, ld;
    logic [1:0] sel;
    logic [3:0] d;
    logic [1:0] cur_sel;
    logic       wrap;
    int         n_cmp = 0;
    int         n_bad = 0;

    dec_scan_pol #(.SEL_W(2), .DWELL(3)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .pol(pol),
        .blank(blank), .ld(ld), .sel(sel), .d(d), .cur_sel(cur_sel), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; pol = 1'b0; blank = 1'b0; ld = 1'b0; sel = 2'd0;
        #2;
        n_cmp++; if (d !== 4'b0000) begin n_bad++; $display("FAIL reset_d got=%b exp=0000", d); end
        n_cmp++; if (cur_sel !== 2'd0) begin n_bad++; $display("FAIL reset_sel got=%0d exp=0", cur_sel); end
        n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
        step();
        rst_n = 1'b1;
        step();
        n_cmp++; if (d !== 4'b1111) begin n_bad++; $display("FAIL idle_d_pol0 got=%b exp=1111", d); end
        n_cmp++; if (cur_sel !== 2'd0) begin n_bad++; $display("FAIL idle_sel got=%0d exp=0", cur_sel); end
        $display("test_reset done: d=%b cur_sel=%0d", d, cur_sel);
    endtask

    task automatic test_direct();
        en = 1'b1; mode = 1'b0; pol = 1'b1; ld = 1'b1; sel = 2'd2;
        step();
        ld = 1'b0; sel = 2'd1;
        n_cmp++; if (cur_sel !== 2'd2) begin n_bad++; $display("FAIL direct_load got=%0d exp=2", cur_sel); end
        n_cmp++; if (d !== 4'b0000) begin n_bad++; $display("FAIL direct_d_k got=%b exp=0000", d); end
        step();
        n_cmp++; if (d !== 4'b0100) begin n_bad++; $display("FAIL direct_d_k1 got=%b exp=0100", d); end
        step();
        n_cmp++; if (cur_sel !== 2'd2) begin n_bad++; $display("FAIL direct_hold got=%0d exp=2", cur_sel); end
        n_cmp++; if (d !== 4'b0100) begin n_bad++; $display("FAIL direct_hold_d got=%b exp=0100", d); end
        $display("test_direct done: d=%b cur_sel=%0d", d, cur_sel);
    endtask

    task automatic test_scan();
        logic [3:0] exp_d;
        logic [1:0] exp_sel;
        en = 1'b0;
        step();
        en = 1'b1; mode = 1'b1;
        step();
        n_cmp++; if (cur_sel !== 2'd0) begin n_bad++; $display("FAIL scan_entry got=%0d exp=0", cur_sel); end
        n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL scan_entry_wrap got=%b exp=0", wrap); end
        for (int j = 1; j <= 13; j++) begin
            step();
            exp_d   = 4'b0001 << (((j - 1) / 3) % 4);
            exp_sel = 2'((j / 3) % 4);
            n_cmp++; if (d !== exp_d) begin n_bad++; $display("FAIL scan_d[%0d] got=%b exp=%b", j, d, exp_d); end
            n_cmp++; if (cur_sel !== exp_sel) begin n_bad++; $display("FAIL scan_sel[%0d] got=%0d exp=%0d", j, cur_sel, exp_sel); end
            n_cmp++; if (wrap !== (j == 12)) begin n_bad++; $display("FAIL scan_wrap[%0d] got=%b exp=%b", j, wrap, (j == 12)); end
        end
        $display("test_scan done: d=%b cur_sel=%0d", d, cur_sel);
    endtask

    task automatic test_pol_blank();
        logic [3:0] exp_d  [5];
        logic [1:0] exp_sel[5];
        exp_d   = '{4'b0100, 4'b1011, 4'b1111, 4'b1111, 4'b0111};
        exp_sel = '{2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
        en = 1'b0; pol = 1'b1;
        step();
        en = 1'b1; mode = 1'b1;
        step();
        for (int j = 1; j <= 6; j++) step();
        for (int k = 0; k < 5; k++) begin
            step();
            n_cmp++; if (d !== exp_d[k]) begin n_bad++; $display("FAIL polblank_d[%0d] got=%b exp=%b", k, d, exp_d[k]); end
            n_cmp++; if (cur_sel !== exp_sel[k]) begin n_bad++; $display("FAIL polblank_sel[%0d] got=%0d exp=%0d", k, cur_sel, exp_sel[k]); end
            if (k == 0) pol = 1'b0;
            if (k == 1) blank = 1'b1;
            if (k == 3) blank = 1'b0;
        end
        step();
        n_cmp++; if (cur_sel !== 2'd0 || wrap !== 1'b1) begin n_bad++; $display("FAIL polblank_wrap got sel=%0d wrap=%b exp sel=0 wrap=1", cur_sel, wrap); end
        pol = 1'b1;
        $display("test_pol_blank done: d=%b cur_sel=%0d", d, cur_sel);
    endtask

    task automatic test_mode_ld();
        mode = 1'b0; ld = 1'b1; sel = 2'd1;
        step();
        n_cmp++; if (cur_sel !== 2'd1) begin n_bad++; $display("FAIL modeld_pre got=%0d exp=1", cur_sel); end
        mode = 1'b1; sel = 2'd3;
        step();
        ld = 1'b0;
        n_cmp++; if (cur_sel !== 2'd0) begin n_bad++; $display("FAIL modeld_ignored got=%0d exp=0", cur_sel); end
        step();
        n_cmp++; if (d !== 4'b0001) begin n_bad++; $display("FAIL modeld_scan_d got=%b exp=0001", d); end
        step(); step();
        n_cmp++; if (cur_sel !== 2'd1) begin n_bad++; $display("FAIL modeld_adv got=%0d exp=1", cur_sel); end
        mode = 1'b0;
        step(); step();
        n_cmp++; if (cur_sel !== 2'd1) begin n_bad++; $display("FAIL scan_to_direct got=%0d exp=1", cur_sel); end
        en = 1'b0; ld = 1'b1; sel = 2'd2;
        step(); step();
        ld = 1'b0;
        n_cmp++; if (cur_sel !== 2'd1) begin n_bad++; $display("FAIL idle_ld got=%0d exp=1", cur_sel); end
        n_cmp++; if (d !== 4'b0000) begin n_bad++; $display("FAIL idle_d_pol1 got=%b exp=0000", d); end
        $display("test_mode_ld done: d=%b cur_sel=%0d", d, cur_sel);
    endtask

    task automatic test_reset_mid_scan();
        en = 1'b1; mode = 1'b1;
        step();
        for (int j = 1; j <= 9; j++) step();
        n_cmp++; if (cur_sel !== 2'd3) begin n_bad++; $display("FAIL rstmid_pre got=%0d exp=3", cur_sel); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (d !== 4'b0000) begin n_bad++; $display("FAIL rstmid_d got=%b exp=0000", d); end
        n_cmp++; if (cur_sel !== 2'd0) begin n_bad++; $display("FAIL rstmid_sel got=%0d exp=0", cur_sel); end
        #2 rst_n = 1'b1;
        step();
        n_cmp++; if (cur_sel !== 2'd0 || wrap !== 1'b0) begin n_bad++; $display("FAIL rstmid_entry got sel=%0d wrap=%b exp sel=0 wrap=0", cur_sel, wrap); end
        for (int j = 1; j <= 2; j++) begin
            step();
            n_cmp++; if (d !== 4'b0001 || wrap !== 1'b0) begin n_bad++; $display("FAIL rstmid_run[%0d] got d=%b wrap=%b exp d=0001 wrap=0", j, d, wrap); end
        end
        $display("test_reset_mid_scan done: d=%b cur_sel=%0d", d, cur_sel);
    endtask

    initial begin
        test_reset();
        test_direct();
        test_scan();
        test_pol_blank();
        test_mode_ld();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
